serial_negate_ctrl: RTL and testbench

//   Sequencer around a bit-serial two's-complement Moore FSM. Accepts a parallel

---
 rtl/serial_negate_ctrl_pkg.sv | 41 ++++
 rtl/serial_negate_ctrl_if.sv | 31 +++
 rtl/serial_negate_ctrl_fsm.sv | 39 +++
 rtl/serial_negate_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_negate_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/serial_negate_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_negate_ctrl_pkg
// Purpose : Shared encodings for the serial negation sequencer. Holds the
//           control FSM states, the bit-serial two's-complement FSM states and
//           its next-state function.
// Ports   : none (package)
// Options : SERIAL_NEGATE_OVF_EN is consumed by serial_negate_ctrl only.
// Revision: 1.0 - initial release
// ============================================================================
package serial_negate_ctrl_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } ctrl_state_e;

  // Serial complementer states; encoding 3 is illegal and recovers to S_IDLE
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ONE  = 2'd1,
    S_ZERO = 2'd2
  } ser_state_e;

  // Copy bits up to and including the first 1, invert every later bit.
  function automatic ser_state_e ser_next(input ser_state_e s, input logic x);
    ser_state_e n;
    case (s)
      S_IDLE:  n = x ? S_ONE  : S_IDLE;
      S_ONE:   n = x ? S_ZERO : S_ONE;
      S_ZERO:  n = x ? S_ZERO : S_ONE;
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_negate_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : serial_negate_ctrl_if
// Purpose : Operand/result handshake bundle of the serial negation sequencer.
// Ports   : in_valid/in_ready/in_data   operand channel (valid/ready)
//           out_valid/out_ready/out_data result channel (valid/ready)
//           modport slave  - the sequencer side
//           modport master - the producer/consumer side
// Revision: 1.0 - initial release
// ============================================================================
interface serial_negate_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/serial_negate_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module  : serial_twos_comp_fsm
// Purpose : Bit-serial two's-complement Moore FSM, LSB first. z is 1 only in
//           state S_ONE. clr returns it to S_IDLE at the next edge.
// Ports   : clk    in  clock, rising edge
//           areset in  asynchronous reset, active-high
//           clr    in  synchronous clear to S_IDLE
//           x      in  serial operand bit
//           z      out serial negated bit (Moore)
// Revision: 1.0 - initial release
// ============================================================================
module serial_twos_comp_fsm
  import serial_negate_ctrl_pkg::*;
(
  input  wire logic clk,
  input  wire logic areset,
  input  wire logic clr,
  input  wire logic x,
  output logic      z
);

  ser_state_e state_q;
  ser_state_e state_d;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_IDLE;
    if (!clr) state_d = ser_next(state_q, x);
  end

  assign z = (state_q == S_ONE);

endmodule
`default_nettype wire

// File: rtl/serial_negate_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : serial_negate_ctrl
// Purpose : Accepts a parallel operand, streams it LSB first through the serial
//           two's-complement FSM and returns (-in_data) mod 2^WIDTH.
// Ports   : clk    in  clock, rising edge
//           areset in  asynchronous reset, active-high
//           bus    slave modport: operand and result valid/ready channels
//           busy   out high whenever the sequencer is not IDLE
//           ovf    out (SERIAL_NEGATE_OVF_EN only) operand was the most
//                      negative value; valid with out_valid
// Options : `define SERIAL_NEGATE_OVF_EN adds the ovf port and detector.
// Revision: 1.0 - initial release
// ============================================================================
module serial_negate_ctrl
  import serial_negate_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             areset,
  serial_negate_ctrl_if.slave   bus,
  output logic                  busy
`ifdef SERIAL_NEGATE_OVF_EN
  ,
  output logic                  ovf
`endif
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  ctrl_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             fsm_clr;
  logic             fsm_z;

  serial_twos_comp_fsm u_fsm (
    .clk    (clk),
    .areset (areset),
    .clr    (fsm_clr),
    .x      (shreg_q[0]),
    .z      (fsm_z)
  );

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    fsm_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          shreg_d = bus.in_data;
          cnt_d   = '0;
          fsm_clr = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q + CNT_ONE;
        // z lags x by one cycle: on the first SHIFT cycle it still reflects
        // the cleared FSM, so nothing is collected yet.
        if (cnt_q != '0) res_d = {fsm_z, res_q[WIDTH-1:1]};
        if (cnt_q == CNT_LAST) state_d = DRAIN;
      end
      DRAIN: begin
        res_d   = {fsm_z, res_q[WIDTH-1:1]};
        state_d = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = res_q;
  assign busy          = (state_q != IDLE);

`ifdef SERIAL_NEGATE_OVF_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == IDLE && bus.in_valid)      ovf_d = (bus.in_data == MOST_NEG);
    else if (state_q == HOLD && bus.out_ready) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q && (state_q == HOLD);
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_negate_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_negate_ctrl
// Purpose : Directed self-checking bench for serial_negate_ctrl (WIDTH=8).
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_negate_ctrl;

  logic clk = 1'b0;
  logic areset = 1'b1;
  logic busy;
`ifdef SERIAL_NEGATE_OVF_EN
  logic ovf;
`endif

  int tests = 0;
  int fails = 0;
  int lat;

  serial_negate_ctrl_if #(.WIDTH(8)) bus ();

  serial_negate_ctrl #(.WIDTH(8)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus),
    .busy   (busy)
`ifdef SERIAL_NEGATE_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count edges from the accepting edge until out_valid appears (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic check_ovf(input logic [7:0] d);
`ifdef SERIAL_NEGATE_OVF_EN
    check("ovf", {31'd0, ovf}, {31'd0, d == 8'h80});
`else
    check("no_ovf_busy", {31'd0, busy}, 32'd1);
`endif
  endtask

  task automatic run_op(input logic [7:0] d, input logic [7:0] exp);
    check("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    wait_valid(lat);
    check("latency", lat, 32'd9);
    check("out_data", {24'd0, bus.out_data}, {24'd0, exp});
    check_ovf(d);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("ready_after_release", {31'd0, bus.in_ready}, 32'd1);
    check("data_held_idle", {24'd0, bus.out_data}, {24'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    areset        = 1'b1;
    tick();
    tick();
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data",  {24'd0, bus.out_data},  32'd0);
    check("rst_busy",      {31'd0, busy},          32'd0);
`ifdef SERIAL_NEGATE_OVF_EN
    check("rst_ovf",       {31'd0, ovf},           32'd0);
`endif
    areset = 1'b0;
    tick();

    // Basic vectors and boundaries
    run_op(8'h05, 8'hFB);
    run_op(8'h00, 8'h00);
    run_op(8'hFF, 8'h01);
    run_op(8'h01, 8'hFF);
    run_op(8'h80, 8'h80);
    run_op(8'h7F, 8'h81);

    // Back-pressure in HOLD
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h2A;
    tick();
    bus.in_valid = 1'b0;
    wait_valid(lat);
    check("bp_latency", lat, 32'd9);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid",    {31'd0, bus.out_valid}, 32'd1);
      check("bp_data",     {24'd0, bus.out_data},  32'hD6);
      check("bp_in_ready", {31'd0, bus.in_ready},  32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_release_ready", {31'd0, bus.in_ready},  32'd1);
    check("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
    check("bp_release_busy",  {31'd0, busy},          32'd0);

    // in_valid held across an operation
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h03;
    tick();
    bus.in_data  = 8'h10;
    tick();
    check("hv_ready_shift", {31'd0, bus.in_ready}, 32'd0);
    wait_valid(lat);
    check("hv_latency1", lat, 32'd8);
    check("hv_data1",    {24'd0, bus.out_data}, 32'hFD);
    check("hv_ready_hold", {31'd0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("hv_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("hv_busy2", {31'd0, busy}, 32'd1);
    wait_valid(lat);
    check("hv_latency2", lat, 32'd9);
    check("hv_data2",    {24'd0, bus.out_data}, 32'hF0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Asynchronous reset during SHIFT (cnt=3)
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h05;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("ar_busy_before", {31'd0, busy}, 32'd1);
    areset = 1'b1;
    #1;
    check("ar_busy",      {31'd0, busy},          32'd0);
    check("ar_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("ar_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("ar_out_data",  {24'd0, bus.out_data},  32'd0);
    #2;
    areset = 1'b0;
    tick();
    run_op(8'h05, 8'hFB);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
